// File: rtl/serial_add_sequencer.sv
// rtl/serial_add_sequencer.sv - bit-serial add/sub sequencer driving an external 1-bit full-adder slice
module serial_add_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] acc;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_bit;

    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_bit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: the +1 enters through the initial carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a  <= '0;
            sh_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= '0;
                        acc   <= '0;
                    end
                end
                RUN: begin
                    acc   <= {fa_sum, acc[WIDTH-1:1]};
                    carry <= fa_cout;
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    cnt   <= cnt + CW'(1);
                    if (last_bit) begin
                        sum  <= {fa_sum, acc[WIDTH-1:1]};
                        cout <= fa_cout;
                        // carry still holds the carry into the MSB here
                        ovf  <= carry ^ fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign fa_a   = busy & sh_a[0];
    assign fa_b   = busy & sh_b[0];
    assign fa_cin = busy & carry;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb/tb_serial_add_sequencer.sv - scoreboard bench for serial_add_sequencer with a behavioural adder slice
module tb_serial_add_sequencer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         fa_a, fa_b, fa_cin, fa_sum, fa_cout;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [5:0]   exp_q[$];
    int           done_times[$];
    logic [5:0]   last_res = '0;
    logic         prev_done = 1'b0;

    serial_add_sequencer #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .sub     (sub),
        .a       (a),
        .b       (b),
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_cin  (fa_cin),
        .fa_sum  (fa_sum),
        .fa_cout (fa_cout),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout),
        .ovf     (ovf)
    );

    // external full-adder slice
    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [5:0] model(input logic [3:0] x, input logic [3:0] y, input logic s);
        logic [3:0] yy;
        logic [4:0] t;
        yy = s ? ~y : y;
        t = {1'b0, x} + {1'b0, yy} + {4'b0, s};
        model = {t[3:0], t[4], (x[3] == yy[3]) && (t[3] != x[3])};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, expv, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!busy) check("fa_idle", {29'b0, fa_a, fa_b, fa_cin}, 0);
        if (done) begin
            check("done_pulse", {31'b0, prev_done}, 0);
            done_times.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done with empty scoreboard at cycle %0d", cyc);
            end else begin
                logic [5:0] e;
                e = exp_q.pop_front();
                check("result", {26'b0, sum, cout, ovf}, {26'b0, e});
                last_res = e;
            end
        end
        prev_done = done;
    end

    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic ts,
                          input logic [5:0] e, input bit noise);
        int n;
        int bc;
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; start = 1'b1;
        @(posedge clk);
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        bc = 0;
        while (!done && n < W + 4) begin
            if (busy) begin
                bc++;
                check("hold", {26'b0, sum, cout, ovf}, {26'b0, last_res});
            end
            if (noise) begin
                a = 4'($urandom); b = 4'($urandom); sub = 1'($urandom); start = 1'($urandom);
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("done_seen", {31'b0, done}, 1);
        check("busy_cycles", bc, W);
    endtask

    initial begin
        logic [3:0] hv[4];
        hv = '{4'h2, 4'h9, 4'hC, 4'h7};

        repeat (2) @(negedge clk);
        check("reset_out", {21'b0, busy, done, sum, cout, ovf, fa_a, fa_b, fa_cin}, 0);
        rst_n = 1'b1;

        run_op(4'd5,  4'd6, 1'b0, 6'b1011_0_1, 1'b0);
        run_op(4'd15, 4'd1, 1'b0, 6'b0000_1_0, 1'b0);
        run_op(4'd3,  4'd5, 1'b1, 6'b1110_0_0, 1'b1);
        run_op(4'd8,  4'd1, 1'b1, 6'b0111_1_1, 1'b1);

        // start held high: one acceptance every W+2 cycles, operands only matter at acceptance
        @(negedge clk);
        done_times.delete();
        start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a = hv[k]; b = 4'h3; sub = 1'b1;
            @(posedge clk);
            exp_q.push_back(model(hv[k], 4'h3, 1'b1));
            for (int j = 0; j < 5; j++) begin
                @(negedge clk);
                a = 4'($urandom); b = 4'($urandom); sub = 1'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("held_ops", done_times.size(), 4);
        if (done_times.size() == 4) begin
            for (int k = 1; k < 4; k++) check("held_spacing", done_times[k] - done_times[k-1], W + 2);
        end

        // asynchronous reset in the middle of RUN
        @(negedge clk);
        a = 4'd5; b = 4'd6; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("mid_reset", {21'b0, busy, done, sum, cout, ovf, fa_a, fa_b, fa_cin}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        last_res = '0;

        run_op(4'd7, 4'd7, 1'b0, 6'b1110_0_1, 1'b0);

        for (int s = 0; s < 2; s++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++)
                    run_op(4'(x), 4'(y), 1'(s), model(4'(x), 4'(y), 1'(s)), ((x + y) % 3) == 0);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
